// File: rtl/cxu_pkg.sv
// Shared widths, state encoding and command payload layout for the CXU
// requester-side initiator.
package cxu_pkg;

  localparam int FUNC_ID_W  = 3;
  localparam int STATE_ID_W = 3;
  localparam int CXU_ID_W   = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } cxu_state_e;

  typedef struct packed {
    logic [FUNC_ID_W-1:0]  function_id;
    logic [DATA_W-1:0]     inputs_0;
    logic [DATA_W-1:0]     inputs_1;
    logic [STATE_ID_W-1:0] state_id;
    logic [CXU_ID_W-1:0]   cxu_id;
  } cxu_cmd_payload_t;

endpackage

// File: rtl/cxu_cmd_initiator_if.sv
// CXU cmd/rsp channel bundle; master is the requester, slave is the CXU.
interface cxu_cmd_initiator_if;
  import cxu_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FUNC_ID_W-1:0]  cmd_payload_function_id;
  logic [DATA_W-1:0]     cmd_payload_inputs_0;
  logic [DATA_W-1:0]     cmd_payload_inputs_1;
  logic [STATE_ID_W-1:0] cmd_payload_state_id;
  logic [CXU_ID_W-1:0]   cmd_payload_cxu_id;
  logic                  cmd_payload_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_payload_outputs_0;
  logic                  rsp_payload_ready;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id,
           cmd_payload_ready, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id,
           cmd_payload_ready, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_ready
  );

endinterface

// File: rtl/cxu_op_timer.sv
// Saturating operation counter with synchronous clear and a terminal-count flag.
module cxu_op_timer #(
  parameter int CNT_W    = 16,
  parameter int TC_VALUE = 254
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(TC_VALUE));

endmodule

// File: rtl/cxu_cmd_initiator.sv
// Requester-side CXU master: one operation outstanding, registered outputs only,
// result presented with timeout flag and cmd-to-completion latency.
module cxu_cmd_initiator
  import cxu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FUNC_ID_W-1:0]  req_function_id,
  input  logic [DATA_W-1:0]     req_inputs_0,
  input  logic [DATA_W-1:0]     req_inputs_1,
  input  logic [STATE_ID_W-1:0] req_state_id,
  input  logic [CXU_ID_W-1:0]   req_cxu_id,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_timeout,
  output logic [CNT_W-1:0]      res_cycles,
  cxu_cmd_initiator_if.master   cxu
);

  localparam logic [1:0]       ST_IDLE   = IDLE;
  localparam logic [1:0]       ST_ISSUE  = ISSUE;
  localparam logic [1:0]       ST_WAIT   = WAIT;
  localparam logic [1:0]       ST_HOLD   = HOLD;
  localparam logic [CNT_W-1:0] TO_CYCLES = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]        state_q;
  cxu_cmd_payload_t  cmd_q;
  logic [DATA_W-1:0] data_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  cycles_q;
  logic [CNT_W-1:0]  count;
  logic              tc;
  logic              in_flight;
  logic              cmd_fire;
  logic              rsp_fire;
  logic              done;
  logic              expire;
  logic              unused_rsp_payload_ready;

  assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign cmd_fire  = cxu.cmd_valid && cxu.cmd_ready;
  assign rsp_fire  = cxu.rsp_valid && cxu.rsp_ready;
  // A rsp without the matching cmd handshake in ISSUE is a protocol error and is dropped.
  assign done      = ((state_q == ST_ISSUE) && cmd_fire && rsp_fire) ||
                     ((state_q == ST_WAIT) && rsp_fire);
  assign expire    = in_flight && tc && !done;
  assign unused_rsp_payload_ready = cxu.rsp_payload_ready;

  cxu_op_timer #(
    .CNT_W    (CNT_W),
    .TC_VALUE (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == ST_IDLE) && req_valid),
    .enable (in_flight),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_q.function_id <= req_function_id;
            cmd_q.inputs_0    <= req_inputs_0;
            cmd_q.inputs_1    <= req_inputs_1;
            cmd_q.state_id    <= req_state_id;
            cmd_q.cxu_id      <= req_cxu_id;
            state_q           <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (done) begin
            data_q    <= cxu.rsp_payload_outputs_0;
            timeout_q <= 1'b0;
            cycles_q  <= count + CNT_W'(1);
            state_q   <= ST_HOLD;
          end else if (expire) begin
            data_q    <= '0;
            timeout_q <= 1'b1;
            cycles_q  <= TO_CYCLES;
            state_q   <= ST_HOLD;
          end else if ((state_q == ST_ISSUE) && cmd_fire) begin
            state_q   <= ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (res_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_HOLD);
  assign res_data    = data_q;
  assign res_timeout = timeout_q;
  assign res_cycles  = cycles_q;

  assign cxu.cmd_valid               = (state_q == ST_ISSUE);
  assign cxu.rsp_ready               = in_flight;
  assign cxu.cmd_payload_function_id = cmd_q.function_id;
  assign cxu.cmd_payload_inputs_0    = cmd_q.inputs_0;
  assign cxu.cmd_payload_inputs_1    = cmd_q.inputs_1;
  assign cxu.cmd_payload_state_id    = cmd_q.state_id;
  assign cxu.cmd_payload_cxu_id      = cmd_q.cxu_id;
  assign cxu.cmd_payload_ready       = 1'b1;

endmodule

// File: tb/tb_cxu_cmd_initiator.sv
// Scoreboard bench for cxu_cmd_initiator driving a configurable CXU model
// (zero-latency, delayed, cmd-stalling, silent).
module tb_cxu_cmd_initiator;
  import cxu_pkg::*;

  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [2:0]    req_function_id, req_state_id;
  logic [31:0]   req_inputs_0, req_inputs_1;
  logic [3:0]    req_cxu_id;
  logic          res_valid, res_ready, res_timeout;
  logic [31:0]   res_data;
  logic [CW-1:0] res_cycles;

  always #5 clk = ~clk;

  cxu_cmd_initiator_if cxu ();

  cxu_cmd_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_function_id (req_function_id),
    .req_inputs_0    (req_inputs_0),
    .req_inputs_1    (req_inputs_1),
    .req_state_id    (req_state_id),
    .req_cxu_id      (req_cxu_id),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_timeout     (res_timeout),
    .res_cycles      (res_cycles),
    .cxu             (cxu.master)
  );

  typedef struct {
    logic [31:0]   data;
    logic          timeout;
    logic [CW-1:0] cycles;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // CXU model: 0 zero-latency, 1 rsp 4 cycles after cmd, 2 cmd stalled 3 cycles, 3 silent
  int          mode;
  int          stall;
  int          dly;
  logic        pend;
  logic [31:0] pend_data;
  logic        pulse;

  function automatic logic [31:0] mulsh(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return p[41:10];
  endfunction

  always_comb begin
    cxu.cmd_ready             = 1'b1;
    cxu.rsp_valid             = 1'b0;
    cxu.rsp_payload_outputs_0 = mulsh(cxu.cmd_payload_inputs_0, cxu.cmd_payload_inputs_1);
    cxu.rsp_payload_ready     = 1'b1;
    case (mode)
      0: begin
        cxu.cmd_ready = cxu.rsp_ready;
        cxu.rsp_valid = cxu.cmd_valid;
      end
      1: begin
        cxu.rsp_valid             = pend && (dly == 4);
        cxu.rsp_payload_outputs_0 = pend_data;
      end
      2: begin
        cxu.cmd_ready = (stall >= 3);
        cxu.rsp_valid = cxu.cmd_valid && (stall >= 3);
      end
      3: cxu.rsp_valid = pulse;
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      stall <= 0;
      dly   <= 0;
      pend  <= 1'b0;
    end else begin
      if (cxu.cmd_valid && !cxu.cmd_ready) stall <= stall + 1;
      else if (!cxu.cmd_valid)             stall <= 0;
      if (mode == 1) begin
        if (cxu.cmd_valid && cxu.cmd_ready) begin
          pend      <= 1'b1;
          dly       <= 1;
          pend_data <= mulsh(cxu.cmd_payload_inputs_0, cxu.cmd_payload_inputs_1);
        end else if (pend) begin
          if (cxu.rsp_valid && cxu.rsp_ready) pend <= 1'b0;
          else                                 dly  <= dly + 1;
        end
      end
    end
  end

  // Payload seen on the cmd channel must match the accepted request for every cmd_valid cycle.
  logic [2:0]  exp_fid, exp_sid;
  logic [31:0] exp_a, exp_b;
  logic [3:0]  exp_cid;

  always @(negedge clk) begin
    if (!reset && cxu.cmd_valid) begin
      check("cmd_fid",   64'(cxu.cmd_payload_function_id), 64'(exp_fid));
      check("cmd_in0",   64'(cxu.cmd_payload_inputs_0),    64'(exp_a));
      check("cmd_in1",   64'(cxu.cmd_payload_inputs_1),    64'(exp_b));
      check("cmd_sid",   64'(cxu.cmd_payload_state_id),    64'(exp_sid));
      check("cmd_cid",   64'(cxu.cmd_payload_cxu_id),      64'(exp_cid));
      check("cmd_pready", 64'(cxu.cmd_payload_ready),      64'd1);
    end
  end

  task automatic issue(input logic [2:0] fid, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sid, input logic [3:0] cid);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid       = 1'b1;
    req_function_id = fid;
    req_inputs_0    = a;
    req_inputs_1    = b;
    req_state_id    = sid;
    req_cxu_id      = cid;
    exp_fid = fid; exp_a = a; exp_b = b; exp_sid = sid; exp_cid = cid;
    @(negedge clk);
    req_valid       = 1'b0;
    req_function_id = '0;
    req_inputs_0    = '0;
    req_inputs_1    = '0;
  endtask

  task automatic get_result(input string tag, input int hold, input logic do_pulse);
    int   n;
    exp_t e;
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    if (!res_valid) return;
    check({tag, "_data"},    64'(res_data),    64'(e.data));
    check({tag, "_timeout"}, 64'(res_timeout), 64'(e.timeout));
    check({tag, "_cycles"},  64'(res_cycles),  64'(e.cycles));
    check({tag, "_hold_req_ready"}, 64'(req_ready),     64'd0);
    check({tag, "_hold_cmd_valid"}, 64'(cxu.cmd_valid), 64'd0);
    check({tag, "_hold_rsp_ready"}, 64'(cxu.rsp_ready), 64'd0);
    if (do_pulse) begin
      pulse = 1'b1;
      check({tag, "_late_rsp_ready"}, 64'(cxu.rsp_ready), 64'd0);
      @(negedge clk);
      pulse = 1'b0;
      check({tag, "_late_data"},    64'(res_data),    64'(e.data));
      check({tag, "_late_timeout"}, 64'(res_timeout), 64'(e.timeout));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"},     64'(res_valid),  64'd1);
      check({tag, "_stall_data"},      64'(res_data),   64'(e.data));
      check({tag, "_stall_cycles"},    64'(res_cycles), 64'(e.cycles));
      check({tag, "_stall_req_ready"}, 64'(req_ready),  64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_after_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_after_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},   64'(req_ready),                   64'd1);
    check({tag, "_cmd_valid"},   64'(cxu.cmd_valid),               64'd0);
    check({tag, "_rsp_ready"},   64'(cxu.rsp_ready),               64'd0);
    check({tag, "_res_valid"},   64'(res_valid),                   64'd0);
    check({tag, "_res_data"},    64'(res_data),                    64'd0);
    check({tag, "_res_timeout"}, 64'(res_timeout),                 64'd0);
    check({tag, "_res_cycles"},  64'(res_cycles),                  64'd0);
    check({tag, "_pl_in0"},      64'(cxu.cmd_payload_inputs_0),    64'd0);
    check({tag, "_pl_fid"},      64'(cxu.cmd_payload_function_id), 64'd0);
    check({tag, "_pl_cid"},      64'(cxu.cmd_payload_cxu_id),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0; mode = 0; pulse = 1'b0;
    req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0;
    req_state_id = '0; req_cxu_id = '0;
    exp_fid = '0; exp_a = '0; exp_b = '0; exp_sid = '0; exp_cid = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Zero-latency CXU, result held 5 cycles before consumption.
    mode = 0;
    sb.push_back('{data: 32'd6000, timeout: 1'b0, cycles: 16'd1});
    issue(3'd2, 32'd3000, 32'd2048, 3'd1, 4'd3);
    get_result("zero_lat", 5, 1'b0);

    // Response four cycles after cmd acceptance.
    mode = 1;
    sb.push_back('{data: 32'hFFFF_FFFB, timeout: 1'b0, cycles: 16'd5});
    issue(3'd1, 32'hFFFF_FC00, 32'd5, 3'd2, 4'd6);
    get_result("delay4", 0, 1'b0);

    // cmd_ready withheld for three ISSUE cycles.
    mode = 2;
    sb.push_back('{data: 32'd7, timeout: 1'b0, cycles: 16'd4});
    issue(3'd5, 32'd1024, 32'd7, 3'd3, 4'd9);
    get_result("stall3", 0, 1'b0);

    // Silent CXU: timeout, then a late rsp pulse must be ignored.
    mode = 3;
    sb.push_back('{data: 32'd0, timeout: 1'b1, cycles: 16'(TO)});
    issue(3'd4, 32'd11, 32'd22, 3'd0, 4'd2);
    get_result("timeout", 2, 1'b1);

    // Reset in the middle of WAIT, then a fresh operation.
    mode = 1;
    issue(3'd3, 32'd500, 32'd600, 3'd5, 4'd7);
    @(negedge clk);
    check("mid_wait_cmd_valid", 64'(cxu.cmd_valid), 64'd0);
    check("mid_wait_rsp_ready", 64'(cxu.rsp_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_wait");
    reset = 1'b0;
    mode = 0;
    sb.push_back('{data: 32'd100, timeout: 1'b0, cycles: 16'd1});
    issue(3'd1, 32'd100, 32'd1024, 3'd0, 4'd1);
    get_result("post_rst", 0, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
